// File: rtl/fetch_redirect_unit_if.sv
// Instruction SRAM port of the fetch front end.
// Request channel: req_valid/req_ready handshake carrying a word-aligned
// req_addr. Response channel: rsp_valid/rsp_data, returned in request order
// and never in the same cycle as the accept. The response has no
// back-pressure.
//   master : fetch unit (drives req_valid/req_addr, receives the rest)
//   slave  : instruction SRAM
interface fetch_redirect_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end. It owns the PC, issues in-order requests to
// the instruction SRAM, and buffers returned words in a small FIFO that
// feeds IF/ID. An EX redirect (i_pc_sel) reloads the PC, empties the FIFO,
// and discards every response still in flight. It also raises the IF/ID and
// ID/EX flushes in the same cycle.
//
// Ports
//   i_clk, i_rst_n    : clock; synchronous active-low reset
//   i_pc_sel          : redirect from EX (priority over stall and issue)
//   i_br_target       : redirect target; the low two bits are ignored
//   i_stall           : hold the instruction presented to IF/ID
//   imem              : SRAM request/response channel (master side)
//   o_instr*          : FIFO head (data, PC, valid) presented to IF/ID
//   o_flush_ifid/idex : combinational copies of i_pc_sel
//   o_misalign        : only when MISALIGN_TRAP_EN is defined. Pulses for
//                       one cycle after a redirect to a target that is not
//                       word-aligned.
//
// Capacity rule: accepted-but-unreturned requests plus buffered words never
// exceed MAX_OUTST. The FIFO therefore cannot overflow, and the PC queue
// cannot overflow either.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pc_sel,
  input  logic [31:0]           i_br_target,
  input  logic                  i_stall,
  fetch_redirect_unit_if.master imem,
  output logic [31:0]           o_instr,
  output logic [31:0]           o_instr_pc,
  output logic                  o_instr_valid,
  output logic                  o_flush_ifid,
  output logic                  o_flush_idex
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  o_misalign
`endif
);

  localparam int              CNT_W = $clog2(MAX_OUTST + 1);
  localparam int              PTR_W = $clog2(MAX_OUTST);
  localparam logic [CNT_W:0]  CAP   = (CNT_W + 1)'(MAX_OUTST);

  typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc;
  logic [CNT_W-1:0]   outst, fifo_cnt, drop_cnt, drop_nxt;
  logic [PTR_W-1:0]   f_rd, f_wr, q_rd, q_wr;
  logic [31:0]        fifo_data [MAX_OUTST];
  logic [31:0]        fifo_pc   [MAX_OUTST];
  logic [31:0]        pcq       [MAX_OUTST];

  logic [CNT_W:0]     occupancy;
  logic               req_valid, req_fire, push, pop, head_valid;
  logic [31:0]        fetch_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Issue / response / delivery decode
  always_comb begin
    fetch_addr = {pc[31:2], 2'b00};
    occupancy  = {1'b0, outst} + {1'b0, fifo_cnt};
    req_valid  = (state != BOOT) && !i_pc_sel && (occupancy < CAP);
    req_fire   = req_valid && imem.req_ready;
    // A response in a redirect cycle belongs to the wrong path as well.
    push       = imem.rsp_valid && !i_pc_sel && (drop_cnt == '0);
    head_valid = (fifo_cnt != '0);
    pop        = head_valid && !i_stall && !i_pc_sel;
  end

  // Squash bookkeeping and next state
  always_comb begin
    drop_nxt  = drop_cnt;
    state_nxt = state;
    if (i_pc_sel)
      drop_nxt = outst - CNT_W'(imem.rsp_valid);
    else if (imem.rsp_valid && (drop_cnt != '0))
      drop_nxt = drop_cnt - 1'b1;
    case (state)
      BOOT:    state_nxt = (drop_nxt != '0) ? SQUASH : RUN;
      RUN,
      SQUASH:  state_nxt = (drop_nxt != '0) ? SQUASH : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Control state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      f_rd     <= '0;
      f_wr     <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      outst    <= outst + CNT_W'(req_fire) - CNT_W'(imem.rsp_valid);
      if (i_pc_sel)
        pc <= {i_br_target[31:2], 2'b00};
      else if (req_fire)
        pc <= fetch_addr + 32'd4;
      // The PC queue tracks every in-flight request, including the ones
      // that will be discarded, so it stays aligned with the response order.
      if (req_fire)
        q_wr <= ptr_inc(q_wr);
      if (imem.rsp_valid)
        q_rd <= ptr_inc(q_rd);
      if (i_pc_sel) begin
        f_rd     <= '0;
        f_wr     <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push)
          f_wr <= ptr_inc(f_wr);
        if (pop)
          f_rd <= ptr_inc(f_rd);
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage (no reset; validity is tracked by the counters above)
  always_ff @(posedge i_clk) begin
    if (req_fire)
      pcq[q_wr] <= fetch_addr;
    if (push) begin
      fifo_data[f_wr] <= imem.rsp_data;
      fifo_pc[f_wr]   <= pcq[q_rd];
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_misalign <= 1'b0;
    else
      o_misalign <= i_pc_sel && (i_br_target[1:0] != 2'b00);
  end
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^i_br_target[1:0];
`endif

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = fetch_addr;
  assign o_instr_valid  = head_valid && !i_pc_sel;
  assign o_instr        = head_valid ? fifo_data[f_rd] : '0;
  assign o_instr_pc     = head_valid ? fifo_pc[f_rd]   : '0;
  assign o_flush_ifid   = i_pc_sel && i_rst_n;
  assign o_flush_idex   = i_pc_sel && i_rst_n;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
`timescale 1ns/1ps
module tb_fetch_redirect_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pc_sel, stall;
  logic [31:0] br_target;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, flush_ifid, flush_idex;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  fetch_redirect_unit_if imem();

  fetch_redirect_unit #(.RESET_PC(32'h0000_0000), .MAX_OUTST(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc_sel     (pc_sel),
    .i_br_target  (br_target),
    .i_stall      (stall),
    .imem         (imem),
    .o_instr      (instr),
    .o_instr_pc   (instr_pc),
    .o_instr_valid(instr_valid),
    .o_flush_ifid (flush_ifid),
    .o_flush_idex (flush_idex)
`ifdef MISALIGN_TRAP_EN
    ,
    .o_misalign   (misalign)
`endif
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected correct-path stream starting at a (new) fetch target.
  task automatic restart_sb(input logic [31:0] t);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(t + 32'(4 * k));
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!instr_valid && n < maxc) begin
      tick();
      #1;
      n++;
    end
    check1(tag, instr_valid, 1'b1);
  endtask

  // SRAM model: in-order responses, lat cycles after the accept.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      pend.delete();
      imem.rsp_valid <= 1'b0;
      imem.rsp_data  <= '0;
    end else begin
      if (imem.req_valid && imem.req_ready)
        pend.push_back('{imem.req_addr, cyc + lat - 1});
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem.rsp_valid <= 1'b1;
        imem.rsp_data  <= mem_word(pend[0].addr);
        pend.delete(0);
      end else begin
        imem.rsp_valid <= 1'b0;
        imem.rsp_data  <= '0;
      end
    end
  end

  // Scoreboard: every instruction consumed by IF/ID is popped and compared.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    #2;
    if (rst_n && instr_valid && !stall && !pc_sel) begin
      check1("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e);
        check("instr_data", instr, mem_word(e));
        delivered++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] head;
    logic        found;
    rst_n = 1'b0; pc_sel = 1'b0; stall = 1'b0; br_target = '0;
    imem.req_ready = 1'b1;
    restart_sb(32'h0);
    repeat (3) tick();
    pc_sel = 1'b1;
    #1;
    check1("rst_req_valid", imem.req_valid, 1'b0);
    check("rst_req_addr", imem.req_addr, 32'h0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check1("rst_flush_ifid", flush_ifid, 1'b0);
    check1("rst_flush_idex", flush_idex, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Boot cycle then sequential fetch.
    tick(); pc_sel = 1'b0; rst_n = 1'b1; #1;
    check1("boot_no_req", imem.req_valid, 1'b0);
    tick(); #1;
    check1("first_req_valid", imem.req_valid, 1'b1);
    check("first_req_addr", imem.req_addr, 32'h0);
    tick(); #1;
    check("second_req_addr", imem.req_addr, 32'h4);
    check1("no_bypass", instr_valid, 1'b0);
    tick(); #1;
    check1("first_instr_valid", instr_valid, 1'b1);
    check("first_instr_pc", instr_pc, 32'h0);
    repeat (10) tick();
    #1;
    check1("run_progress", delivered > 3, 1'b1);

    // Stall for three cycles: head held, issue stops at capacity.
    wait_valid("stall_head_valid", 10);
    stall = 1'b1;
    head = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      check1("stall_valid", instr_valid, 1'b1);
      check("stall_pc_held", instr_pc, head);
      check("stall_data_held", instr, mem_word(head));
      if (k == 2) check1("stall_capacity", imem.req_valid, 1'b0);
      tick();
      #1;
    end
    stall = 1'b0;
    repeat (8) tick();

    // Redirect with two requests in flight (3-cycle SRAM).
    imem.req_ready = 1'b0;
    repeat (8) tick();
    lat = 3; imem.req_ready = 1'b1; #1;
    check1("p3_issue0", imem.req_valid, 1'b1);
    tick(); #1;
    check1("p3_issue1", imem.req_valid, 1'b1);
    tick(); br_target = 32'h100; pc_sel = 1'b1; restart_sb(32'h100); #1;
    check1("p3_flush_ifid", flush_ifid, 1'b1);
    check1("p3_flush_idex", flush_idex, 1'b1);
    check1("p3_req_forced_low", imem.req_valid, 1'b0);
    check1("p3_instr_forced_low", instr_valid, 1'b0);
    tick(); pc_sel = 1'b0; #1;
    check("p3_target_addr", imem.req_addr, 32'h100);
    wait_valid("p3_valid", 20);
    check("p3_first_pc", instr_pc, 32'h100);
    repeat (10) tick();

    // Redirect coincident with the only returning response.
    imem.req_ready = 1'b0;
    repeat (10) tick();
    lat = 1; imem.req_ready = 1'b1; #1;
    check1("p4_issue", imem.req_valid, 1'b1);
    tick(); br_target = 32'h300; pc_sel = 1'b1; restart_sb(32'h300); #1;
    check1("p4_flush", flush_ifid, 1'b1);
    check1("p4_req_forced_low", imem.req_valid, 1'b0);
    tick(); pc_sel = 1'b0; #1;
    check1("p4_req_valid", imem.req_valid, 1'b1);
    check("p4_addr", imem.req_addr, 32'h300);
    check1("p4_nothing_buffered", instr_valid, 1'b0);
    wait_valid("p4_valid", 10);
    check("p4_first_pc", instr_pc, 32'h300);

    // SRAM not ready at 0x20; redirect during the wait.
    repeat (4) tick();
    br_target = 32'h20; pc_sel = 1'b1; imem.req_ready = 1'b0; restart_sb(32'h20);
    tick(); pc_sel = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("p5_addr_hold", imem.req_addr, 32'h20);
      if (k >= 2) check1("p5_req_waiting", imem.req_valid, 1'b1);
      tick();
    end
    br_target = 32'h40; pc_sel = 1'b1; restart_sb(32'h40); #1;
    check("p5_addr_in_redirect", imem.req_addr, 32'h20);
    tick(); pc_sel = 1'b0; imem.req_ready = 1'b1; #1;
    check("p5_addr_redirected", imem.req_addr, 32'h40);
    repeat (8) tick();

    // PC wrap past 0xFFFF_FFFC.
    br_target = 32'hFFFF_FFF8; pc_sel = 1'b1; restart_sb(32'hFFFF_FFF8);
    tick(); pc_sel = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      #1;
      if (imem.req_valid && imem.req_addr == 32'hFFFF_FFFC) found = 1'b1;
      else tick();
    end
    check1("p6_last_word_issued", found, 1'b1);
    tick(); #1;
    check("p6_wrap_addr", imem.req_addr, 32'h0);
    repeat (12) tick();

`ifdef MISALIGN_TRAP_EN
    br_target = 32'h102; pc_sel = 1'b1; restart_sb(32'h100); #1;
    check1("mis_idle", misalign, 1'b0);
    tick(); pc_sel = 1'b0; #1;
    check1("mis_pulse", misalign, 1'b1);
    check("mis_aligned_addr", imem.req_addr, 32'h100);
    tick(); #1;
    check1("mis_clear", misalign, 1'b0);
    wait_valid("mis_valid", 10);
    check("mis_first_pc", instr_pc, 32'h100);
    repeat (4) tick();
`endif

    // Reset in mid-operation.
    rst_n = 1'b0;
    tick(); #1;
    check1("rst2_req_valid", imem.req_valid, 1'b0);
    check1("rst2_instr_valid", instr_valid, 1'b0);
    check("rst2_req_addr", imem.req_addr, 32'h0);
    check1("total_delivered", delivered > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
